// File: rtl/keypad_debouncer.sv
// Keypad front end: classifies {h,v}, debounces press and release, and emits one key event per press.
// Optional KEYPAD_SYNC_EN adds a 2-flop input synchronizer ahead of classification.
module keypad_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:3] h,
  input  logic [1:4] v,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic       multi_err
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam bit               NO_FILTER  = (DEBOUNCE_CYCLES == 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic [6:0]       pat, pat_next;
  logic [6:0]       samp;
  logic             is_zero, is_key;
  logic             valid_next, err_next, held_next;
  logic [3:0]       code_next;

`ifdef KEYPAD_SYNC_EN
  logic [6:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {h, v};
      sync2 <= sync1;
    end
  end

  assign samp = sync2;
`else
  assign samp = {h, v};
`endif

  assign is_zero = (samp == 7'd0);
  assign is_key  = ($countones(samp[6:4]) == 1) && ($countones(samp[3:0]) == 1);
  // Saturating increment: the count never moves past the debounce target.
  assign cnt_inc = (cnt >= CNT_TARGET) ? cnt : cnt + CNT_ONE;

  function automatic logic [3:0] decode(input logic [6:0] p);
    logic [3:0] c;
    c = 4'h0;
    case (p)
      7'b100_1000: c = 4'h1;
      7'b010_1000: c = 4'h2;
      7'b001_1000: c = 4'h3;
      7'b100_0100: c = 4'h4;
      7'b010_0100: c = 4'h5;
      7'b001_0100: c = 4'h6;
      7'b100_0010: c = 4'h7;
      7'b010_0010: c = 4'h8;
      7'b001_0010: c = 4'h9;
      7'b100_0001: c = 4'hA;
      7'b010_0001: c = 4'h0;
      7'b001_0001: c = 4'hB;
      default:     c = 4'h0;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pat       <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      key_held  <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      pat       <= pat_next;
      key_valid <= valid_next;
      key_code  <= code_next;
      key_held  <= held_next;
      multi_err <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pat_next   = pat;
    valid_next = 1'b0;
    err_next   = 1'b0;
    code_next  = key_code;
    case (state)
      IDLE: begin
        if (is_key) begin
          pat_next = samp;
          cnt_next = CNT_ONE;
          if (NO_FILTER) begin
            valid_next = 1'b1;
            code_next  = decode(samp);
            state_next = PRESSED;
          end else begin
            state_next = DEBOUNCE;
          end
        end else if (!is_zero) begin
          err_next = 1'b1;
        end
      end
      DEBOUNCE: begin
        if (is_key && samp == pat) begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_TARGET) begin
            valid_next = 1'b1;
            code_next  = decode(samp);
            state_next = PRESSED;
          end
        end else if (is_key) begin
          pat_next = samp;
          cnt_next = CNT_ONE;
        end else begin
          // Both a release and a bad pattern abandon the candidate key.
          err_next   = !is_zero;
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      PRESSED: begin
        if (is_zero) begin
          if (NO_FILTER) begin
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next   = CNT_ONE;
            state_next = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (is_zero) begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_TARGET) begin
            cnt_next   = '0;
            state_next = IDLE;
          end
        end else begin
          state_next = PRESSED;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
    held_next = (state_next == PRESSED) || (state_next == RELEASE);
  end

endmodule

// File: tb/tb_keypad_debouncer.sv
// Self-checking bench for keypad_debouncer: an N=1 and an N=4 instance share the keypad lines
// and are compared every cycle against a run-length reference model, plus table and directed checks.
module tb_keypad_debouncer;

`ifdef KEYPAD_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [1:3] h;
  logic [1:4] v;
  logic       kv1, kh1, me1, kv4, kh4, me4;
  logic [3:0] kc1, kc4;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  keypad_debouncer #(.DEBOUNCE_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clock), .reset(reset), .h(h), .v(v),
    .key_valid(kv1), .key_code(kc1), .key_held(kh1), .multi_err(me1)
  );

  keypad_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut4 (
    .clk(clock), .reset(reset), .h(h), .v(v),
    .key_valid(kv4), .key_code(kc4), .key_held(kh4), .multi_err(me4)
  );

  // Reference model: per instance, length of the current stable key run while unlocked,
  // and length of the current all-zero run while a key is locked.
  int         modelN[2] = '{1, 4};
  int         runLen[2];
  logic [6:0] runPat[2];
  bit         locked[2];
  int         zeroRun[2];
  bit         expValid[2];
  bit         expErr[2];
  logic [3:0] expCode[2];
  logic [6:0] hist[$];

  int         pulses1, pulses4, errs1, heldCyc1;
  logic [3:0] lastCode1, lastCode4;
  logic [3:0] codeLog1[$];

  function automatic logic [3:0] codeOf(input logic [6:0] s);
    int col = 0;
    int row = 0;
    for (int c = 0; c < 3; c++) if (s[6-c]) col = c + 1;
    for (int r = 0; r < 4; r++) if (s[3-r]) row = r + 1;
    if (row < 4) return 4'((row - 1) * 3 + col);
    if (col == 1) return 4'hA;
    if (col == 2) return 4'h0;
    return 4'hB;
  endfunction

  task automatic modelStep(input bit rst, input logic [6:0] s);
    bit isZero = (s == 7'd0);
    bit isKey  = ($countones(s[6:4]) == 1) && ($countones(s[3:0]) == 1);
    for (int i = 0; i < 2; i++) begin
      expValid[i] = 1'b0;
      expErr[i]   = 1'b0;
      if (rst) begin
        runLen[i] = 0; runPat[i] = '0; locked[i] = 1'b0; zeroRun[i] = 0; expCode[i] = 4'h0;
      end else if (!locked[i]) begin
        if (isKey) begin
          runLen[i] = (runLen[i] > 0 && s == runPat[i]) ? runLen[i] + 1 : 1;
          runPat[i] = s;
          if (runLen[i] == modelN[i]) begin
            expValid[i] = 1'b1;
            expCode[i]  = codeOf(s);
            locked[i]   = 1'b1;
            runLen[i]   = 0;
            zeroRun[i]  = 0;
          end
        end else begin
          expErr[i] = !isZero;
          runLen[i] = 0;
        end
      end else begin
        zeroRun[i] = isZero ? zeroRun[i] + 1 : 0;
        if (zeroRun[i] == modelN[i]) begin
          locked[i]  = 1'b0;
          zeroRun[i] = 0;
        end
      end
    end
  endtask

  task automatic compare(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    compare("valid1", kv1, expValid[0]);
    compare("code1",  kc1, expCode[0]);
    compare("held1",  kh1, locked[0]);
    compare("err1",   me1, expErr[0]);
    compare("valid4", kv4, expValid[1]);
    compare("code4",  kc4, expCode[1]);
    compare("held4",  kh4, locked[1]);
    compare("err4",   me4, expErr[1]);
    compare("excl1",  kv1 & me1, 0);
    compare("excl4",  kv4 & me4, 0);
    if (kv1) begin pulses1++; lastCode1 = kc1; codeLog1.push_back(kc1); end
    if (kv4) begin pulses4++; lastCode4 = kc4; end
    if (me1) errs1++;
    if (kh1) heldCyc1++;
  endtask

  task automatic applyStimulus(input logic [2:0] hh, input logic [3:0] vv, input bit rst);
    logic [6:0] s;
    h = hh; v = vv; reset = rst;
    @(posedge clock);
    if (rst) begin
      hist.delete();
      for (int k = 0; k < SYNC_LAT; k++) hist.push_back(7'd0);
      modelStep(1'b1, 7'd0);
    end else begin
      hist.push_back({hh, vv});
      s = hist.pop_front();
      modelStep(1'b0, s);
    end
    @(negedge clock);
    checkOutput();
  endtask

  task automatic hold(input logic [2:0] hh, input logic [3:0] vv, input int n);
    for (int k = 0; k < n; k++) applyStimulus(hh, vv, 1'b0);
  endtask

  task automatic clearCounts();
    pulses1 = 0; pulses4 = 0; errs1 = 0; heldCyc1 = 0;
    codeLog1.delete();
  endtask

  typedef struct {
    logic [2:0] hh;
    logic [3:0] vv;
    logic [3:0] code;
  } keyVec_t;

  keyVec_t keyTable[12];

  initial begin
    keyTable[0]  = '{3'b100, 4'b1000, 4'h1};
    keyTable[1]  = '{3'b010, 4'b1000, 4'h2};
    keyTable[2]  = '{3'b001, 4'b1000, 4'h3};
    keyTable[3]  = '{3'b100, 4'b0100, 4'h4};
    keyTable[4]  = '{3'b010, 4'b0100, 4'h5};
    keyTable[5]  = '{3'b001, 4'b0100, 4'h6};
    keyTable[6]  = '{3'b100, 4'b0010, 4'h7};
    keyTable[7]  = '{3'b010, 4'b0010, 4'h8};
    keyTable[8]  = '{3'b001, 4'b0010, 4'h9};
    keyTable[9]  = '{3'b100, 4'b0001, 4'hA};
    keyTable[10] = '{3'b010, 4'b0001, 4'h0};
    keyTable[11] = '{3'b001, 4'b0001, 4'hB};

    h = '0; v = '0; reset = 1'b1;
    applyStimulus(3'b000, 4'b0000, 1'b1);
    applyStimulus(3'b000, 4'b0000, 1'b1);
    compare("rst_code", kc1, 0);
    compare("rst_held", kh1, 0);

    // Single one-cycle press on the unfiltered instance.
    clearCounts();
    hold(3'b100, 4'b1000, 1);
    hold(3'b000, 4'b0000, SYNC_LAT + 2);
    compare("t1_pulses", pulses1, 1);
    compare("t1_code", lastCode1, 1);
    compare("t1_held", heldCyc1, 1);

    // Key map table.
    for (int i = 0; i < 12; i++) begin
      clearCounts();
      hold(keyTable[i].hh, keyTable[i].vv, 1);
      hold(3'b000, 4'b0000, SYNC_LAT + 1);
      compare("tbl_pulses", pulses1, 1);
      compare("tbl_code", lastCode1, keyTable[i].code);
    end

    // Back-to-back keys with a single zero cycle between.
    clearCounts();
    hold(3'b100, 4'b1000, 1); hold(3'b000, 4'b0000, 1);
    hold(3'b100, 4'b1000, 1); hold(3'b000, 4'b0000, 1);
    hold(3'b010, 4'b0001, 1); hold(3'b000, 4'b0000, 1);
    hold(3'b010, 4'b0100, 1); hold(3'b000, 4'b0000, SYNC_LAT + 2);
    compare("t2_pulses", pulses1, 4);
    compare("t2_count", codeLog1.size(), 4);
    if (codeLog1.size() == 4) begin
      compare("t2_c0", codeLog1[0], 1);
      compare("t2_c1", codeLog1[1], 1);
      compare("t2_c2", codeLog1[2], 0);
      compare("t2_c3", codeLog1[3], 5);
    end

    // Two columns at once is rejected and leaves the old code.
    clearCounts();
    hold(3'b110, 4'b1000, 1);
    hold(3'b000, 4'b0000, SYNC_LAT + 2);
    compare("t3_err", errs1, 1);
    compare("t3_pulses", pulses1, 0);
    compare("t3_code", kc1, 5);

    // Filtered instance: 3, 4 and 10 cycle holds of key 6.
    clearCounts();
    hold(3'b001, 4'b0100, 3); hold(3'b000, 4'b0000, 8);
    compare("t4_short", pulses4, 0);
    clearCounts();
    hold(3'b001, 4'b0100, 4); hold(3'b000, 4'b0000, 8);
    compare("t4_exact", pulses4, 1);
    compare("t4_code", lastCode4, 6);
    clearCounts();
    hold(3'b001, 4'b0100, 10); hold(3'b000, 4'b0000, 8);
    compare("t4_long", pulses4, 1);

    // Bounce on press and on release.
    clearCounts();
    hold(3'b010, 4'b0100, 2); hold(3'b000, 4'b0000, 1);
    hold(3'b010, 4'b0100, 4); hold(3'b000, 4'b0000, 2);
    hold(3'b010, 4'b0100, 2); hold(3'b000, 4'b0000, 4 + SYNC_LAT);
    compare("t5_pulses", pulses4, 1);
    compare("t5_code", lastCode4, 5);
    compare("t5_held", kh4, 0);

    // Reset while held, then the still-held key counts as a fresh press.
    hold(3'b100, 4'b0001, 2 + SYNC_LAT);
    compare("t6_held_before", kh1, 1);
    compare("t6_code_before", kc1, 4'hA);
    applyStimulus(3'b100, 4'b0001, 1'b1);
    compare("t6_code_rst", kc1, 0);
    compare("t6_held_rst", kh1, 0);
    compare("t6_valid_rst", kv1, 0);
    clearCounts();
    hold(3'b100, 4'b0001, 6 + SYNC_LAT);
    compare("t6_fresh1", pulses1, 1);
    compare("t6_fresh4", pulses4, 1);
    hold(3'b001, 4'b0001, 1);
    hold(3'b000, 4'b0000, 8);

    // Randomized segments of keys, zeros and bad patterns.
    for (int seg = 0; seg < 300; seg++) begin
      int sel;
      int len;
      logic [6:0] pat;
      sel = $urandom_range(0, 99);
      len = $urandom_range(1, 6);
      if (sel < 50) begin
        int k = $urandom_range(0, 11);
        pat = {keyTable[k].hh, keyTable[k].vv};
      end else if (sel < 75) begin
        pat = 7'd0;
      end else begin
        pat = 7'($urandom_range(1, 127));
      end
      if (sel == 99) applyStimulus(3'b000, 4'b0000, 1'b1);
      hold(pat[6:4], pat[3:0], len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
